// File: rtl/instr_byte_tx_if.sv
// Producer-side and byte-bus signals of the instruction-byte transmitter.
//   in_valid/in_ready/in_opcode/in_addr : word push handshake
//   data/ena                            : byte bus and strobe to the receiver
//   busy/level                          : status
interface instr_byte_tx_if #(
  parameter int unsigned PTR_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [12:0]      in_addr;
  logic [7:0]       data;
  logic             ena;
  logic             busy;
  logic [PTR_W:0]   level;

  modport master (
    output in_valid, in_opcode, in_addr,
    input  in_ready, data, ena, busy, level
  );

  modport slave (
    input  in_valid, in_opcode, in_addr,
    output in_ready, data, ena, busy, level
  );
endinterface

// File: rtl/instr_byte_tx.sv
// Instruction-byte link transmitter: queues {addr, opcode} words in a FIFO
// and sends each as two bytes (high first) with ENA high for exactly two cycles,
// followed by at least IDLE_GAP ENA-low cycles.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : instr_byte_tx_if.slave (push handshake, DATA/ENA, BUSY/LEVEL)
// Optional build macro DATA_BUS_HIZ_EN: DATA floats (8'bz) whenever ENA is low.
module instr_byte_tx #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  instr_byte_tx_if.slave bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic [1:0] {IDLE, HI, LO, GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]    r_level, w_level_nxt;
  logic [WORD_W-1:0]   r_hold, w_hold_nxt;
  logic [WORD_W-1:0]   w_head;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_ena, w_ena_nxt;
  logic                r_busy, w_busy_nxt;
  logic [GAP_W-1:0]    r_gap, w_gap_nxt;
  logic                w_push, w_pop, w_launch;

  assign bus.in_ready = (r_level != LVL_W'(DEPTH));
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_head       = r_mem[r_rd_ptr];

  // A GAP state whose counter has expired is treated as IDLE, so a queued
  // word launches straight away and the ENA-low run is exactly IDLE_GAP.
  assign w_launch = (r_level != '0) &&
                    ((r_state == IDLE) || ((r_state == GAP) && (r_gap == '0)));

  // Next-state, output byte and FIFO level
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_data_nxt  = 8'h00;
    w_ena_nxt   = 1'b0;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    w_level_nxt = r_level;

    case (r_state)
      IDLE: ;
      HI: begin
        w_state_nxt = LO;
        w_ena_nxt   = 1'b1;
        w_data_nxt  = r_hold[7:0];
      end
      LO: begin
        w_state_nxt = GAP;
        w_gap_nxt   = GAP_W'(IDLE_GAP - 1);
      end
      GAP: begin
        if (r_gap == '0) w_state_nxt = IDLE;
        else             w_gap_nxt   = r_gap - GAP_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_launch) begin
      w_state_nxt = HI;
      w_pop       = 1'b1;
      w_hold_nxt  = w_head;
      w_ena_nxt   = 1'b1;
      w_data_nxt  = w_head[15:8];
    end

    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE) || (w_level_nxt != '0);
  end

  // FIFO storage needs no reset; only the pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_addr, bus.in_opcode};
  end

  // State, pointers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_hold   <= '0;
      r_data   <= 8'h00;
      r_ena    <= 1'b0;
      r_busy   <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_hold   <= w_hold_nxt;
      r_data   <= w_data_nxt;
      r_ena    <= w_ena_nxt;
      r_busy   <= w_busy_nxt;
      r_gap    <= w_gap_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  assign bus.ena   = r_ena;
  assign bus.busy  = r_busy;
  assign bus.level = r_level;

`ifdef DATA_BUS_HIZ_EN
  assign bus.data = r_ena ? r_data : 8'bz;
`else
  assign bus.data = r_data;
`endif

endmodule

// File: doc/instr_byte_tx.md
Name: instr_byte_tx

Overview:
- Transmit side of the 8-bit instruction-byte link.
- Queues 16-bit instruction words, each formed from a 3-bit opcode and a 13-bit address.
- Emits each word as two bytes on DATA, high byte first, qualified by ENA held high for exactly two consecutive cycles.
- Used by the program loader / test driver to feed the instruction register over the shared 8-bit bus.

Parameters:
- DEPTH, 4, number of word entries in the input FIFO; power of 2, minimum 2.
- PTR_W, 2, FIFO pointer width; must equal log2(DEPTH).
- IDLE_GAP, 1, minimum ENA-low cycles between consecutive words; range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  producer presents a word.
- IN_READY  output  1  FIFO can accept a word (not full).
- IN_OPCODE  input  3  opcode field; packed into word[2:0].
- IN_ADDR  input  13  address field; packed into word[15:3].
- DATA  output  8  byte bus to the receiver.
- ENA  output  1  byte strobe; high for the HI and LO cycles of each word only.
- BUSY  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- LEVEL  output  PTR_W+1  number of words currently held in the FIFO.

Behaviour:
- Word packing: word = {IN_ADDR, IN_OPCODE}.
  - High byte = word[15:8] = IN_ADDR[12:5].
  - Low byte = word[7:0] = {IN_ADDR[4:0], IN_OPCODE}.
- Reset (RST_N low, asynchronous):
  - ENA=0, DATA=8'h00, LEVEL=0, IN_READY=1, BUSY=0.
  - FIFO pointers cleared; FSM to IDLE; gap counter cleared.
  - A word in flight is dropped. ENA falling resynchronises the receiver, so no half-word is ever completed.
- FIFO:
  - Push when IN_VALID && IN_READY at the clock edge.
  - IN_READY = (LEVEL != DEPTH), combinational from registered LEVEL.
  - Pop occurs only on the IDLE->HI transition.
  - Simultaneous push and pop: LEVEL unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
  - IN_VALID with IN_READY=0 is ignored. Producer holds the word.
- FSM states: IDLE, HI, LO, GAP. DATA and ENA are registered.
  - IDLE: ENA=0, DATA=0.
    - If LEVEL!=0: pop head into hold register; next state HI; ENA<=1; DATA<=word[15:8].
  - HI: next state LO; ENA stays 1; DATA<=word[7:0].
  - LO: next state GAP; ENA<=0; DATA<=0; gap counter<=IDLE_GAP-1.
  - GAP: decrement counter; at 0 go to IDLE.
- Latency and throughput:
  - Word pushed at edge N into an empty FIFO with FSM in IDLE: ENA high after edge N+1 (high byte) and after edge N+2 (low byte); ENA low after edge N+3.
  - The receiver captures the bytes at edges N+2 and N+3.
  - Back-to-back throughput: one word per 3+IDLE_GAP-1 cycles. With IDLE_GAP=1, one word every 3 cycles: 2 ENA-high cycles + 1 ENA-low cycle.
- Invariants:
  - ENA is never high for other than exactly 2 consecutive cycles.
  - DATA is 0 whenever ENA=0 (default build).
- No bypass path: a push to an empty FIFO always takes the one-cycle latency above.

Optional Feature:
- Macro: DATA_BUS_HIZ_EN.
- Defined: DATA is driven 8'bz whenever ENA=0, including during reset, so the block can share the bus with RAM/ROM. Internal byte register behaves identically.
- Undefined: DATA is driven 8'h00 whenever ENA=0.

Test Plan:
- Reset, then push one word with OPCODE=3'b101, ADDR=13'h1ABC (word 16'hD5E5) -> ENA high 2 cycles; DATA=8'hD5 then 8'hE5; then ENA=0, DATA=0; LEVEL returns to 0; BUSY drops after GAP.
- Push 5 words back-to-back with DEPTH=4 while the FSM is draining -> IN_READY deasserts exactly when LEVEL=4; all 5 words emitted in order; each followed by exactly IDLE_GAP ENA-low cycles.
- IDLE_GAP=3, two queued words -> 3 ENA-low cycles between the second ENA-high pair of word 1 and the first of word 2.
- Assert RST_N low asynchronously during the HI cycle -> ENA and DATA go 0 immediately without a clock; LEVEL=0; no LO byte emitted; the next pushed word is emitted complete.
- Push and pop in the same edge with LEVEL=2 -> LEVEL stays 2; read pointer wraps from DEPTH-1 to 0 correctly across 8 words.
- Build with DATA_BUS_HIZ_EN -> DATA=8'bz in IDLE, GAP and reset; valid bytes only during ENA.
